// File: rtl/countdown_scheduler_pkg.sv
// rtl/countdown_scheduler_pkg.sv - shared encodings and widths for the countdown scheduler
package countdown_scheduler_pkg;

   localparam int CNT_W = 4;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } ch_state_t;

endpackage

// File: rtl/countdown_scheduler_dec4_unit.sv
// rtl/countdown_scheduler_dec4_unit.sv - shared combinational decrementer with borrow out
module dec4_unit
   import countdown_scheduler_pkg::*;
(
   input  logic [CNT_W-1:0] a,
   output logic [CNT_W-1:0] out,
   output logic             uf
);

   // Zero-extend and subtract one; the borrow lands in uf
   always_comb begin
      {uf, out} = {1'b0, a} - (CNT_W+1)'(1);
   end

endmodule

// File: rtl/countdown_scheduler.sv
// rtl/countdown_scheduler.sv - round-robin multi-channel countdown sharing one decrementer
module countdown_scheduler
   import countdown_scheduler_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int CH_W   = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tick_en,
   input  logic              load_valid,
   input  logic [CH_W-1:0]   load_ch,
   input  logic [CNT_W-1:0]  load_val,
   output logic              load_ready,
   output logic [NUM_CH-1:0] busy,
   output logic [NUM_CH-1:0] done,
   output logic              grant_valid,
   output logic [CH_W-1:0]   grant_ch
);

   ch_state_t        state [NUM_CH];
   logic [CNT_W-1:0] cnt   [NUM_CH];
   logic [CH_W-1:0]  rr_ptr;

   logic [CH_W-1:0]  sel;
   logic [CH_W-1:0]  idx;
   logic             found;
   logic             grant;
   logic [CNT_W-1:0] dec_out;
   logic             dec_uf;

   // Loads are never back-pressured; ready simply reflects being out of reset
   assign load_ready = ~rst;

   // Expose per-channel ACTIVE flags straight from the state registers
   always_comb begin
      busy = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         busy[i] = (state[i] == ST_ACTIVE);
      end
   end

   // Round-robin search: first ACTIVE channel at or after rr_ptr, wrapping to 0
   always_comb begin
      found = 1'b0;
      sel   = rr_ptr;
      idx   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         idx = rr_ptr + CH_W'(i);
         if (!found && state[idx] == ST_ACTIVE) begin
            found = 1'b1;
            sel   = idx;
         end
      end
   end

   assign grant = tick_en & found;

   dec4_unit u_dec (
      .a   (cnt[sel]),
      .out (dec_out),
      .uf  (dec_uf)
   );

   // Per-channel state/count update: decrement write-back first, a load on the same channel overrides it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            state[i] <= ST_IDLE;
            cnt[i]   <= '0;
         end
         rr_ptr      <= '0;
         done        <= '0;
         grant_valid <= 1'b0;
         grant_ch    <= '0;
      end else begin
         done        <= '0;
         grant_valid <= grant;
         if (grant) begin
            assert (!dec_uf);
            grant_ch   <= sel;
            rr_ptr     <= sel + 1'b1;
            cnt[sel]   <= dec_out;
            if (dec_out == '0) begin
               state[sel] <= ST_IDLE;
               done[sel]  <= 1'b1;
            end
         end
         if (load_valid) begin
            if (load_val != '0) begin
               cnt[load_ch]   <= load_val;
               state[load_ch] <= ST_ACTIVE;
               done[load_ch]  <= 1'b0;
            end else begin
               cnt[load_ch]   <= '0;
               state[load_ch] <= ST_IDLE;
               done[load_ch]  <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_countdown_scheduler.sv
// tb/tb_countdown_scheduler.sv - scoreboard bench for the countdown scheduler
module tb_countdown_scheduler;

   localparam int NUM_CH = 4;
   localparam int CH_W   = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              tick_en;
   logic              load_valid;
   logic [CH_W-1:0]   load_ch;
   logic [3:0]        load_val;
   logic              load_ready;
   logic [NUM_CH-1:0] busy;
   logic [NUM_CH-1:0] done;
   logic              grant_valid;
   logic [CH_W-1:0]   grant_ch;

   countdown_scheduler #(.NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .tick_en     (tick_en),
      .load_valid  (load_valid),
      .load_ch     (load_ch),
      .load_val    (load_val),
      .load_ready  (load_ready),
      .busy        (busy),
      .done        (done),
      .grant_valid (grant_valid),
      .grant_ch    (grant_ch)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [NUM_CH-1:0] busy;
      logic [NUM_CH-1:0] done;
      logic              gv;
      logic [CH_W-1:0]   gch;
   } exp_t;

   exp_t sb[$];

   int m_cnt [NUM_CH];
   bit m_act [NUM_CH];
   int m_ptr;

   int gr_count   [NUM_CH];
   int done_count [NUM_CH];
   int gr_at_done [NUM_CH];
   int grant_log[$];
   int gated_grants;

   task automatic model_reset();
      for (int k = 0; k < NUM_CH; k++) begin
         m_cnt[k] = 0;
         m_act[k] = 0;
      end
      m_ptr = 0;
      sb.delete();
   endtask

   task automatic clear_obs();
      for (int k = 0; k < NUM_CH; k++) begin
         gr_count[k]   = 0;
         done_count[k] = 0;
         gr_at_done[k] = -1;
      end
      grant_log.delete();
      gated_grants = 0;
   endtask

   // One clock: drive inputs, predict the outputs after the edge, then compare
   task automatic cycle(input bit t, input bit lv, input int lch, input int lval);
      exp_t e;
      exp_t got_e;
      int   g;
      tick_en    = t;
      load_valid = lv;
      load_ch    = lch[CH_W-1:0];
      load_val   = lval[3:0];
      e.done = '0;
      e.gv   = 1'b0;
      e.gch  = '0;
      g = -1;
      if (t) begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (g < 0 && m_act[(m_ptr + k) % NUM_CH]) g = (m_ptr + k) % NUM_CH;
         end
      end
      if (g >= 0) begin
         e.gv  = 1'b1;
         e.gch = g[CH_W-1:0];
         m_cnt[g] = m_cnt[g] - 1;
         if (m_cnt[g] == 0) begin
            m_act[g]  = 0;
            e.done[g] = 1'b1;
         end
         m_ptr = (g + 1) % NUM_CH;
      end
      if (lv) begin
         if (lval != 0) begin
            m_cnt[lch]  = lval;
            m_act[lch]  = 1;
            e.done[lch] = 1'b0;
         end else begin
            m_cnt[lch]  = 0;
            m_act[lch]  = 0;
            e.done[lch] = 1'b1;
         end
      end
      for (int k = 0; k < NUM_CH; k++) e.busy[k] = m_act[k];
      sb.push_back(e);

      @(posedge clk);
      #1;
      got_e = sb.pop_front();
      chk("busy", 32'(busy), 32'(got_e.busy));
      chk("done", 32'(done), 32'(got_e.done));
      chk("grant_valid", 32'(grant_valid), 32'(got_e.gv));
      if (got_e.gv) chk("grant_ch", 32'(grant_ch), 32'(got_e.gch));

      if (grant_valid) begin
         gr_count[grant_ch]++;
         grant_log.push_back(int'(grant_ch));
         if (!t) gated_grants++;
      end
      for (int k = 0; k < NUM_CH; k++) begin
         if (done[k]) begin
            done_count[k]++;
            gr_at_done[k] = gr_count[k];
         end
      end
      tick_en    = 1'b0;
      load_valid = 1'b0;
   endtask

   initial begin
      rst        = 1'b1;
      tick_en    = 1'b0;
      load_valid = 1'b0;
      load_ch    = '0;
      load_val   = '0;
      model_reset();
      clear_obs();

      // Reset values
      #1;
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_gv", 32'(grant_valid), 32'h0);
      chk("rst_gch", 32'(grant_ch), 32'h0);
      chk("rst_load_ready", 32'(load_ready), 32'h0);
      #11;
      rst = 1'b0;
      #1;
      chk("load_ready_out_of_reset", 32'(load_ready), 32'h1);

      // Single channel: ch0 = 3
      clear_obs();
      cycle(1, 1, 0, 3);
      for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0);
      chk("single_grants", 32'(gr_count[0]), 32'd3);
      chk("single_done_count", 32'(done_count[0]), 32'd1);
      chk("single_done_after_grant", 32'(gr_at_done[0]), 32'd3);

      // Two channels, alternating service
      clear_obs();
      cycle(1, 1, 0, 2);
      cycle(1, 1, 1, 2);
      for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0);
      chk("two_grant_total", 32'(grant_log.size()), 32'd4);
      if (grant_log.size() == 4) begin
         chk("two_order0", 32'(grant_log[0]), 32'd0);
         chk("two_order1", 32'(grant_log[1]), 32'd1);
         chk("two_order2", 32'(grant_log[2]), 32'd0);
         chk("two_order3", 32'(grant_log[3]), 32'd1);
      end
      chk("two_done0", 32'(gr_at_done[0]), 32'd2);
      chk("two_done1", 32'(gr_at_done[1]), 32'd2);

      // Zero load completes without the decrementer
      clear_obs();
      cycle(1, 1, 2, 0);
      chk("zero_done2", 32'(done[2]), 32'h1);
      chk("zero_busy2", 32'(busy[2]), 32'h0);
      chk("zero_gv", 32'(grant_valid), 32'h0);
      cycle(1, 0, 0, 0);
      chk("zero_done_one_cycle", 32'(done[2]), 32'h0);

      // Full range with tick gating
      clear_obs();
      cycle(1, 1, 3, 15);
      for (int i = 0; i < 34; i++) cycle((i % 2) == 0, 0, 0, 0);
      chk("full_grants", 32'(gr_count[3]), 32'd15);
      chk("full_done_count", 32'(done_count[3]), 32'd1);
      chk("full_done_after_grant", 32'(gr_at_done[3]), 32'd15);
      chk("full_gated_grants", 32'(gated_grants), 32'd0);

      // Collision: grant and reload of ch1 at the same edge
      clear_obs();
      cycle(0, 1, 1, 1);
      cycle(1, 1, 1, 5);
      chk("col_gv", 32'(grant_valid), 32'h1);
      chk("col_gch", 32'(grant_ch), 32'h1);
      chk("col_no_done", 32'(done[1]), 32'h0);
      chk("col_busy", 32'(busy[1]), 32'h1);
      clear_obs();
      for (int i = 0; i < 7; i++) cycle(1, 0, 0, 0);
      chk("col_grants_after", 32'(gr_count[1]), 32'd5);
      chk("col_done_after", 32'(gr_at_done[1]), 32'd5);
      chk("col_done_count", 32'(done_count[1]), 32'd1);

      // Reset mid-count with ch0 = 7, ch1 = 4 active and rr_ptr away from 0
      cycle(0, 1, 0, 7);
      cycle(0, 1, 1, 4);
      #3;
      rst = 1'b1;
      #1;
      chk("mid_rst_busy", 32'(busy), 32'h0);
      chk("mid_rst_done", 32'(done), 32'h0);
      chk("mid_rst_gv", 32'(grant_valid), 32'h0);
      chk("mid_rst_gch", 32'(grant_ch), 32'h0);
      chk("mid_rst_load_ready", 32'(load_ready), 32'h0);
      #10;
      chk("mid_rst_held_done", 32'(done), 32'h0);
      chk("mid_rst_held_busy", 32'(busy), 32'h0);
      rst = 1'b0;
      model_reset();
      clear_obs();
      cycle(0, 1, 3, 2);
      cycle(0, 1, 0, 2);
      for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0);
      chk("post_rst_grants", 32'(grant_log.size()), 32'd4);
      if (grant_log.size() > 0) chk("post_rst_first_grant", 32'(grant_log[0]), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Absolute time bound so the run always ends
   initial begin
      #200000;
      failures++;
      $display("FAIL timeout got=running exp=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/countdown_scheduler.md
# countdown_scheduler

Multi-channel countdown scheduler that shares a single 4-bit decrement datapath among `NUM_CH` independent countdown channels. Software or upstream logic loads a start value into a channel. The scheduler grants the shared decrementer to one active channel per enabled cycle, in round-robin order, and pulses that channel's `done` when its count reaches zero. It sits between the load/control logic and the decrement unit, and is the only block that sequences that unit.

## Interface
- `NUM_CH`, default 4: number of channels. Must be a power of two in the range 2..8.
- `CH_W`, default 2: channel index width, `log2(NUM_CH)`.

Ports (name, direction, width, meaning):
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `tick_en`, input, 1: allows one decrement to be scheduled this cycle.
- `load_valid`, input, 1: load request.
- `load_ch`, input, `CH_W`: target channel of the load.
- `load_val`, input, 4: start value.
- `load_ready`, output, 1: always 1 when out of reset; 0 during reset.
- `busy`, output, `NUM_CH`: per-channel ACTIVE flag.
- `done`, output, `NUM_CH`: per-channel one-cycle completion pulse.
- `grant_valid`, output, 1: a decrement was performed this cycle (registered).
- `grant_ch`, output, `CH_W`: channel that was decremented.

## Operation
- Per-channel state is IDLE or ACTIVE, plus a 4-bit count register.
- **Load** (`load_valid` at the edge):
  - `load_val != 0`: count is set to `load_val` and the channel becomes ACTIVE.
  - `load_val == 0`: the channel stays or goes IDLE, and `done[load_ch]` pulses without using the decrementer.
  - Loading an ACTIVE channel restarts it.
- **Arbitration**: when `tick_en` = 1 and any channel is ACTIVE, grant the first ACTIVE channel at or after `rr_ptr`, searching upward with wrap `NUM_CH-1` → 0. After a grant, `rr_ptr` becomes `grant + 1`, mod `NUM_CH`. With no grant, `rr_ptr` holds.
- **Decrement**:
  - The granted count is driven through the shared 4-bit decrementer: `{uf, out} = {0, cnt} - 1`, 5-bit arithmetic.
  - `out` is written back.
  - If `out == 0`, the channel goes IDLE and `done` pulses.
  - `uf` must never be 1, because an ACTIVE count is always ≥ 1. Assert on it in simulation.
- **Load and grant on the same channel in the same cycle**: the load wins and the decrement result is discarded. `grant_valid` still reports the grant.
- **Load vs. grant on different channels**: independent; both take effect.
- `tick_en` = 0: no grant and no count change. Loads are still accepted.

## Timing
- **Reset values**:
  - All counts 0, all channels IDLE.
  - `rr_ptr` = 0.
  - `busy` = 0, `done` = 0, `grant_valid` = 0, `grant_ch` = 0, `load_ready` = 0.
- **Reset mid-count**: all state is cleared immediately and no `done` is emitted.
- **Load latency**: load accepted at edge N → `busy` high after N. The channel is eligible for a grant at edge N+1.
- **Decrement latency**: one decrement per granted edge.
- **Completion**: a channel loaded with V and served every cycle pulses `done` for exactly one cycle, starting V edges after its first grant edge minus one. Put simply, `done` is high in the cycle after the edge where the count went 1 → 0, and `busy` falls at that same edge.
- **Registered outputs**: `grant_valid` and `grant_ch` are registered and refer to the edge just taken.
- **Throughput**: at most one decrement per cycle in aggregate. With K active channels, each is served every K enabled cycles.

## Structure
- Shared package holds:
  - the channel state encoding (`ST_IDLE` = 0, `ST_ACTIVE` = 1);
  - the count width constant `CNT_W` = 4.
- Sub-module `dec4_unit`: purely combinational `{uf, out} = {0, a} - 1`, instantiated exactly once.
- Top-level contents:
  - round-robin priority search, implemented as a for-loop over `NUM_CH`;
  - per-channel state and count registers;
  - write-back mux.

## Test plan
- **Single channel**: load ch0 = 3 with `tick_en` held at 1.
  - Grants to ch0 on 3 consecutive edges; counts go 3 → 2 → 1 → 0.
  - `done[0]` is high for one cycle after the third grant; `busy[0]` falls at that edge.
- **Two channels**: load ch0 = 2 and ch1 = 2 on consecutive cycles.
  - `grant_ch` alternates 0, 1, 0, 1.
  - `done[0]` pulses after the 3rd grant and `done[1]` after the 4th.
  - No `uf` assertion fires.
- **Zero load**: load ch2 = 0.
  - `done[2]` pulses in the next cycle; `busy[2]` stays 0; `grant_valid` stays 0.
- **Full-range count and tick gating**: load ch3 = 15, toggling `tick_en` 1/0.
  - Exactly 15 grants; count never changes on `tick_en` = 0 cycles.
  - `done[3]` is seen once, after the 15th grant.
- **Collision**: ch1 = 1 is granted at the same edge as a load of ch1 = 5.
  - No `done[1]`; count is 5; `busy[1]` stays 1.
  - Afterwards, 5 more grants are needed before `done[1]`.
- **Reset mid-count**: assert `rst` asynchronously with ch0 = 7 and ch1 = 4 active.
  - All outputs go to 0 immediately; no `done` pulses.
  - After release, round-robin restarts at ch0.
